// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle for the iterative multiplier.
// master drives operands and out_ready, slave returns the product.
interface shift_add_multiplier_if #(
  parameter int xlen = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [xlen-1:0]   a;
  logic [xlen-1:0]   b;
  logic              kill;
  logic              out_valid;
  logic              out_ready;
  logic [2*xlen-1:0] product;

  modport master (
    output in_valid,
    output a,
    output b,
    output kill,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  kill,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier around a ripple adder.
// One add-and-shift step per cycle, full 2*xlen-bit product.
module ripple_carry_adder #(
  parameter int xlen = 64
) (
  input  logic [xlen-1:0] a,
  input  logic [xlen-1:0] b,
  input  logic            carry_in,
  output logic [xlen-1:0] sum,
  output logic            carry_out
);
  logic [xlen:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < xlen; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  assign carry_out = c[xlen];
endmodule

module shift_add_multiplier #(
  parameter int xlen = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(xlen);
  localparam logic [CW-1:0] LAST = CW'(xlen - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [xlen-1:0]   m;
  logic [xlen-1:0]   m_n;
  logic [2*xlen-1:0] p;
  logic [2*xlen-1:0] p_n;

  logic [xlen-1:0]   sum;
  logic              carry;
  logic [xlen:0]     hi;
  logic [2*xlen-1:0] p_step;

  ripple_carry_adder #(
    .xlen(xlen)
  ) u_add (
    .a        (p[2*xlen-1:xlen]),
    .b        (m),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry)
  );

  // Carry lands in the top bit after the shift, so it is never lost.
  assign hi     = p[0] ? {carry, sum}
                       : {1'b0, p[2*xlen-1:xlen]};
  assign p_step = {hi, p[xlen-1:1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      count <= '0;
      m     <= '0;
      p     <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      m     <= m_n;
      p     <= p_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    m_n     = m;
    p_n     = p;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          m_n     = bus.a;
          p_n     = {{xlen{1'b0}}, bus.b};
          count_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        p_n     = p_step;
        count_n = count + CW'(1);
        if (count == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (bus.kill) begin
      state_n = IDLE;
      count_n = '0;
      m_n     = m;
      p_n     = p;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = p;
endmodule
